avalon_pio_cmd_master: RTL and testbench

- Avalon-MM master that drives the HPS-visible PIO register slaves (write-data/readdata, address, chipselect, write_n) from inside the FPGA fabric.
- Lets the LB accelerator FSM issue register writes and reads without the HPS bridge.
- Commands enter through a valid/ready port and are buffered in a small FIFO. They are issued one at a time on the bus, honouring waitrequest.
- Read results return on a one-cycle response strobe.

---
 rtl/avalon_pio_cmd_master.sv | 179 +++++++++++++++++
 tb/tb_avalon_pio_cmd_master.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_cmd_master.sv
// Avalon-MM command master for the PIO register slaves.
// Commands arrive on a valid/ready port and wait in a small FIFO. They are
// issued one at a time on the bus, and each transfer holds while the slave
// asserts waitrequest. When a read completes, its data is returned with a
// one-cycle rsp_valid pulse.
module avalon_pio_cmd_master #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;

  // Head-of-queue fields
  logic               head_write_s;
  logic [ADDR_W-1:0]  head_address_s;
  logic [DATA_W-1:0]  head_writedata_s;

  // FSM and next values of the registered outputs
  state_t             state_r;
  state_t             state_nxt_s;
  logic [ADDR_W-1:0]  address_nxt_s;
  logic [DATA_W-1:0]  writedata_nxt_s;
  logic               chipselect_nxt_s;
  logic               write_n_nxt_s;
  logic               read_n_nxt_s;
  logic               rsp_valid_nxt_s;
  logic [DATA_W-1:0]  rsp_readdata_nxt_s;

  // A full FIFO refuses commands even if a pop happens in the same cycle,
  // so there is no push-through.
  assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign cmd_ready = !full_s;
  assign push_s    = cmd_valid && !full_s;
  assign busy      = (state_r == ST_XFER) || !empty_s;

  assign {head_write_s, head_address_s, head_writedata_s} = fifo_mem_r[rd_ptr_r];

  // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage write; contents need no reset because the pointers qualify them
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      fifo_mem_r[wr_ptr_r] <= {cmd_write, cmd_address, cmd_writedata};
    end
  end

  // Next-state and next-output logic for the bus FSM
  always_comb begin
    state_nxt_s        = state_r;
    pop_s              = 1'b0;
    address_nxt_s      = avm_address;
    writedata_nxt_s    = avm_writedata;
    chipselect_nxt_s   = avm_chipselect;
    write_n_nxt_s      = avm_write_n;
    read_n_nxt_s       = avm_read_n;
    rsp_valid_nxt_s    = 1'b0;
    rsp_readdata_nxt_s = rsp_readdata;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s            = 1'b1;
          address_nxt_s    = head_address_s;
          writedata_nxt_s  = head_writedata_s;
          chipselect_nxt_s = 1'b1;
          write_n_nxt_s    = !head_write_s;
          read_n_nxt_s     = head_write_s;
          state_nxt_s      = ST_XFER;
        end else begin
          chipselect_nxt_s = 1'b0;
          write_n_nxt_s    = 1'b1;
          read_n_nxt_s     = 1'b1;
        end
      end
      ST_XFER: begin
        if (!avm_waitrequest) begin
          // Transfer completes at this edge; a read also captures its data.
          chipselect_nxt_s = 1'b0;
          write_n_nxt_s    = 1'b1;
          read_n_nxt_s     = 1'b1;
          state_nxt_s      = ST_IDLE;
          if (!avm_read_n) begin
            rsp_valid_nxt_s    = 1'b1;
            rsp_readdata_nxt_s = avm_readdata;
          end else begin
            rsp_valid_nxt_s    = 1'b0;
          end
        end else begin
          state_nxt_s = ST_XFER;
        end
      end
      default: begin
        chipselect_nxt_s = 1'b0;
        write_n_nxt_s    = 1'b1;
        read_n_nxt_s     = 1'b1;
        state_nxt_s      = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered bus/response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      avm_address    <= {ADDR_W{1'b0}};
      avm_writedata  <= {DATA_W{1'b0}};
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read_n     <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_readdata   <= {DATA_W{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      avm_address    <= address_nxt_s;
      avm_writedata  <= writedata_nxt_s;
      avm_chipselect <= chipselect_nxt_s;
      avm_write_n    <= write_n_nxt_s;
      avm_read_n     <= read_n_nxt_s;
      rsp_valid      <= rsp_valid_nxt_s;
      rsp_readdata   <= rsp_readdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_avalon_pio_cmd_master.sv
// Testbench for avalon_pio_cmd_master: directed scenarios plus a random run.
// Every scenario is checked against a cycle-level transaction model.
module tb_avalon_pio_cmd_master;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic        rsp_valid;
  logic [31:0] rsp_readdata;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic        avm_read_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;

  int checks = 0;
  int errors = 0;

  avalon_pio_cmd_master #(.ADDR_W(2), .DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of accepted-but-not-issued commands, the command on
  // the bus, and the last response.
  typedef struct packed {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
  } cmd_t;

  cmd_t        q[$];
  cmd_t        m_cur;
  bit          m_xfer;
  bit          m_acc;
  bit          m_rsp_v;
  logic [31:0] m_rsp_d;
  logic [1:0]  m_addr;
  logic [31:0] m_wdata;

  // Advance the model by one clock edge using the current inputs, then step.
  task automatic tick();
    int pre;
    pre   = q.size();
    m_acc = 1'b0;
    if (reset) begin
      q.delete();
      m_xfer  = 1'b0;
      m_rsp_v = 1'b0;
      m_rsp_d = 32'h0;
      m_addr  = 2'd0;
      m_wdata = 32'h0;
    end else begin
      m_rsp_v = 1'b0;
      if (m_xfer) begin
        if (!avm_waitrequest) begin
          m_xfer = 1'b0;
          if (!m_cur.w) begin
            m_rsp_v = 1'b1;
            m_rsp_d = avm_readdata;
          end
        end
      end else if (pre != 0) begin
        m_cur   = q.pop_front();
        m_xfer  = 1'b1;
        m_addr  = m_cur.a;
        m_wdata = m_cur.d;
      end
      if (cmd_valid && pre < DEPTH) begin
        q.push_back({cmd_write, cmd_address, cmd_writedata});
        m_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; cmd_valid = 1'b0; avm_waitrequest = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd1;
    cmd_writedata = 32'h55; avm_waitrequest = 1'b0; avm_readdata = 32'h0;
    tick();
    checks++;
    if ({avm_chipselect, avm_write_n, avm_read_n, avm_address, avm_writedata} !== {1'b1 ^ 1'b1, 1'b1, 1'b1, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset_bus: got cs=%b wn=%b rn=%b a=%0d d=%h, expected cs=0 wn=1 rn=1 a=0 d=0",
               avm_chipselect, avm_write_n, avm_read_n, avm_address, avm_writedata);
    end
    checks++;
    if ({rsp_valid, rsp_readdata, busy, cmd_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_misc: got rv=%b rd=%h busy=%b rdy=%b, expected 0 0 0 1",
               rsp_valid, rsp_readdata, busy, cmd_ready);
    end
    reset = 1'b0; cmd_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || avm_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: got busy=%b cs=%b, expected 0 0", busy, avm_chipselect);
    end
  endtask

  task automatic test_write_no_stall();
    bit saw_rsp;
    apply_reset();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0; cmd_writedata = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (avm_chipselect !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_n1: got cs=%b busy=%b, expected cs=0 busy=1", avm_chipselect, busy);
    end
    tick();
    checks++;
    if ({avm_chipselect, avm_write_n, avm_read_n, avm_address, avm_writedata} !== {1'b1, 1'b0, 1'b1, 2'd0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL wr_strobe: got cs=%b wn=%b rn=%b a=%0d d=%h, expected 1 0 1 0 deadbeef",
               avm_chipselect, avm_write_n, avm_read_n, avm_address, avm_writedata);
    end
    saw_rsp = rsp_valid;
    tick();
    saw_rsp = saw_rsp | rsp_valid;
    checks++;
    if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_end: got cs=%b wn=%b busy=%b, expected 0 1 0", avm_chipselect, avm_write_n, busy);
    end
    tick();
    saw_rsp = saw_rsp | rsp_valid;
    checks++;
    if (saw_rsp !== 1'b0) begin
      errors++;
      $display("FAIL wr_no_rsp: got rsp_valid seen=%b, expected 0", saw_rsp);
    end
  endtask

  task automatic test_read_stall();
    apply_reset();
    avm_waitrequest = 1'b1; avm_readdata = 32'hFFFF0000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd2; cmd_writedata = 32'h0;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({avm_chipselect, avm_read_n, avm_write_n, avm_address, rsp_valid} !== {1'b1, 1'b0, 1'b1, 2'd2, 1'b0}) begin
        errors++;
        $display("FAIL rd_hold cycle %0d: got cs=%b rn=%b wn=%b a=%0d rv=%b, expected 1 0 1 2 0",
                 k, avm_chipselect, avm_read_n, avm_write_n, avm_address, rsp_valid);
      end
      if (k == 3) begin
        avm_waitrequest = 1'b0; avm_readdata = 32'h12345678;
      end
      tick();
    end
    avm_readdata = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_readdata !== 32'h12345678 || avm_read_n !== 1'b1) begin
      errors++;
      $display("FAIL rd_rsp: got rv=%b rd=%h rn=%b, expected 1 12345678 1", rsp_valid, rsp_readdata, avm_read_n);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_readdata !== 32'h12345678) begin
      errors++;
      $display("FAIL rd_hold_data: got rv=%b rd=%h, expected 0 12345678", rsp_valid, rsp_readdata);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] seen[$];
    int idx;
    bit prev_cs;
    apply_reset();
    avm_waitrequest = 1'b1; idx = 0; prev_cs = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (c == 10) begin
        checks++;
        if (idx != 5 || cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_fill: got accepted=%0d ready=%b, expected 5 0", idx, cmd_ready);
        end
        avm_waitrequest = 1'b0;
      end
      cmd_valid = (idx < 6); cmd_write = 1'b1; cmd_address = 2'(idx);
      cmd_writedata = 32'h100 + 32'(idx);
      checks++;
      if (cmd_ready !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL full_ready cycle %0d: got %b expected %b", c, cmd_ready, (q.size() < DEPTH));
      end
      tick();
      if (m_acc) idx++;
      checks++;
      if (avm_chipselect !== m_xfer || (m_xfer && avm_writedata !== m_wdata)) begin
        errors++;
        $display("FAIL full_bus cycle %0d: got cs=%b d=%h expected cs=%b d=%h",
                 c, avm_chipselect, avm_writedata, m_xfer, m_wdata);
      end
      if (avm_chipselect && !prev_cs) seen.push_back(avm_writedata);
      prev_cs = avm_chipselect;
    end
    cmd_valid = 1'b0;
    checks++;
    if (seen.size() != 6) begin
      errors++;
      $display("FAIL full_count: got %0d transfers, expected 6", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 6; i++) begin
      checks++;
      if (seen[i] !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL full_order[%0d]: got %h expected %h", i, seen[i], 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_mixed();
    logic [35:0] seen[$];
    logic [35:0] exp_seq[3];
    int nrsp;
    logic [31:0] rdat;
    bit prev_cs;
    apply_reset();
    exp_seq[0] = {1'b0, 1'b1, 2'd0, 32'h1};
    exp_seq[1] = {1'b1, 1'b0, 2'd1, 32'h0};
    exp_seq[2] = {1'b0, 1'b1, 2'd0, 32'h2};
    avm_waitrequest = 1'b0; avm_readdata = 32'hA5; nrsp = 0; rdat = 32'h0; prev_cs = 1'b0;
    for (int c = 0; c < 14; c++) begin
      cmd_valid = (c < 3);
      cmd_write = (c != 1);
      cmd_address = (c == 1) ? 2'd1 : 2'd0;
      cmd_writedata = (c == 0) ? 32'h1 : ((c == 2) ? 32'h2 : 32'h0);
      tick();
      if (avm_chipselect && !prev_cs) seen.push_back({avm_write_n, avm_read_n, avm_address, avm_writedata});
      prev_cs = avm_chipselect;
      if (rsp_valid) begin
        nrsp++;
        rdat = rsp_readdata;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (seen.size() != 3) begin
      errors++;
      $display("FAIL mix_count: got %0d transfers, expected 3", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 3; i++) begin
      checks++;
      if (seen[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL mix_order[%0d]: got %h expected %h", i, seen[i], exp_seq[i]);
      end
    end
    checks++;
    if (nrsp != 1 || rdat !== 32'hA5 || rsp_readdata !== 32'hA5) begin
      errors++;
      $display("FAIL mix_rsp: got pulses=%0d data=%h hold=%h, expected 1 a5 a5", nrsp, rdat, rsp_readdata);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    int idx;
    bit prev_cs;
    apply_reset();
    avm_waitrequest = 1'b0; idx = 0; prev_cs = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cmd_valid = (idx < 10); cmd_write = 1'b1; cmd_address = 2'(idx);
      cmd_writedata = 32'(idx);
      tick();
      if (m_acc) idx++;
      if (avm_chipselect && !prev_cs) seen.push_back(avm_writedata);
      prev_cs = avm_chipselect;
    end
    cmd_valid = 1'b0;
    checks++;
    if (seen.size() != 10) begin
      errors++;
      $display("FAIL wrap_count: got %0d transfers, expected 10", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 10; i++) begin
      checks++;
      if (seen[i] !== 32'(i)) begin
        errors++;
        $display("FAIL wrap_data[%0d]: got %0d expected %0d", i, seen[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    avm_waitrequest = 1'b1; avm_readdata = 32'hCAFE0001;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd3; cmd_writedata = 32'h0;
    tick();
    cmd_write = 1'b1; cmd_address = 2'd1; cmd_writedata = 32'h77;
    tick();
    cmd_writedata = 32'h88;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (avm_chipselect !== 1'b1 || avm_read_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got cs=%b rn=%b busy=%b, expected 1 0 1", avm_chipselect, avm_read_n, busy);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; avm_waitrequest = 1'b0;
    checks++;
    if ({avm_chipselect, avm_read_n, avm_write_n, busy, rsp_valid, rsp_readdata} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL mid_reset: got cs=%b rn=%b wn=%b busy=%b rv=%b rd=%h, expected 0 1 1 0 0 0",
               avm_chipselect, avm_read_n, avm_write_n, busy, rsp_valid, rsp_readdata);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (avm_chipselect !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet cycle %0d: got cs=%b rv=%b busy=%b, expected 0 0 0",
                 c, avm_chipselect, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      cmd_valid       = 1'($urandom_range(0, 1));
      cmd_write       = 1'($urandom_range(0, 1));
      cmd_address     = 2'($urandom_range(0, 3));
      cmd_writedata   = $urandom;
      avm_waitrequest = ($urandom_range(0, 3) == 0);
      avm_readdata    = $urandom;
      checks++;
      if (cmd_ready !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_ready cycle %0d: got %b expected %b", c, cmd_ready, (q.size() < DEPTH));
      end
      tick();
      checks++;
      if (avm_chipselect !== m_xfer || avm_write_n !== !(m_xfer && m_cur.w) ||
          avm_read_n !== !(m_xfer && !m_cur.w) || avm_address !== m_addr || avm_writedata !== m_wdata) begin
        errors++;
        $display("FAIL rnd_bus cycle %0d: got cs=%b wn=%b rn=%b a=%0d d=%h expected cs=%b a=%0d d=%h",
                 c, avm_chipselect, avm_write_n, avm_read_n, avm_address, avm_writedata, m_xfer, m_addr, m_wdata);
      end
      checks++;
      if (rsp_valid !== m_rsp_v || rsp_readdata !== m_rsp_d || busy !== (m_xfer || q.size() != 0)) begin
        errors++;
        $display("FAIL rnd_rsp cycle %0d: got rv=%b rd=%h busy=%b expected rv=%b rd=%h busy=%b",
                 c, rsp_valid, rsp_readdata, busy, m_rsp_v, m_rsp_d, (m_xfer || q.size() != 0));
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 2'd0;
    cmd_writedata = 32'h0; avm_readdata = 32'h0; avm_waitrequest = 1'b0;
    m_xfer = 1'b0; m_rsp_v = 1'b0; m_rsp_d = 32'h0; m_addr = 2'd0; m_wdata = 32'h0;
    m_cur = '0; m_acc = 1'b0;
    test_reset();
    test_write_no_stall();
    test_read_stall();
    test_fifo_full();
    test_mixed();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
